vdp_cpu_port: RTL and testbench
===============================

Name: vdp_cpu_port

Overview:
- CPU-facing front end of the VDP, modelled on the TMS9918A programming interface.
- Decodes CPU accesses to the VDP data and control ports: two-byte address/register writes, an auto-incrementing 14-bit VRAM address, and a read-ahead buffer.
- Arbitrates CPU VRAM traffic against display-fetch reads and is the single master of the external memory controller's VDP read/write request port.
- Sits directly upstream of the memory controller's VDP port.

Parameters:
- ADDR_W, 14, VRAM byte-address width; addresses wrap modulo 2^ADDR_W.
- NREGS, 8, number of VDP write-only registers; indexed by second-byte bits [2:0].

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_rq  in  1  one-cycle CPU port access strobe
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_rq
- cpu_mode  in  1  0 = data port, 1 = control/status port
- cpu_wdata  in  8  CPU write byte
- cpu_rdata  out  8  CPU read byte; valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse per cpu_rq
- status_in  in  8  VDP status byte, returned on control reads
- status_rd  out  1  one-cycle pulse when status is read; the status owner clears its flags on it
- vdp_regs  out  8*NREGS  register file, reg0 in [7:0]
- disp_rd_rq  in  1  display fetch read request pulse
- disp_addr  in  ADDR_W  display fetch address; held until disp_ack
- disp_data  out  8  display fetch byte; valid with disp_ack
- disp_ack  out  1  one-cycle pulse
- vdp_addr  out  ADDR_W  VRAM byte address to the memory controller
- vdp_wdata  out  8  VRAM write byte
- vdp_rdata  in  8  VRAM read byte from the memory controller
- vdp_read_rq  out  1  one-cycle read request pulse
- vdp_read_ack  in  1  read completion pulse; vdp_rdata valid in the same cycle
- vdp_write_rq  out  1  one-cycle write request pulse
- vdp_write_ack  in  1  write completion pulse
- vdp_pipeline_reads  out  1  tied 0; the pipelined read mode is not used

Behaviour:
- Reset:
  - All outputs 0; vdp_regs 0.
  - Internal state cleared: addr=0, readbuf=0, first_byte_flag=0, latch=0, state=IDLE, all pendings cleared.
  - Any in-flight VRAM transaction is abandoned and its late ack is ignored, because state is IDLE.
- States: IDLE, DISP_RD, CPU_RD, CPU_WR.
  - Request pulse is issued on the cycle of entry.
  - Exit to IDLE on the matching ack.
  - vdp_addr and vdp_wdata are held stable from entry until the ack.
- IDLE priority: pending display read > pending CPU VRAM op.
  - disp_rd_rq is latched as pending if it arrives while not IDLE.
  - The display ack delivers disp_data = vdp_rdata, registered, with disp_ack.
- CPU control write (cpu_mode=1, cpu_we=1), acked the next cycle:
  - flag=0: latch <= byte; flag <= 1.
  - flag=1, byte[7]=1: vdp_regs[byte[2:0]] <= latch.
  - flag=1, byte[7]=0: addr <= {byte[5:0], latch}. If byte[6]=0, queue a read-ahead with the ack deferred until the read-ahead completes; otherwise ack the next cycle.
  - Flag is cleared on the second byte.
- Control read: cpu_rdata <= status_in; status_rd pulse; flag <= 0; acked the next cycle.
- Data write: flag <= 0; readbuf <= byte; queue VRAM write at addr; addr <= addr+1 at queue time. cpu_ack on vdp_write_ack.
- Data read: flag <= 0; cpu_rdata <= readbuf; queue read-ahead at addr; addr <= addr+1. cpu_ack on read-ahead completion, where readbuf <= vdp_rdata.
- Read-ahead (from the address-set sequence): readbuf <= vdp_rdata; addr <= addr+1.
- One CPU op at a time. cpu_rq while a CPU op is outstanding is ignored, with no ack; the CPU obeys the handshake.
- Address wrap: 3FFF+1 = 0000.
- Simultaneous disp_rd_rq and a CPU VRAM op queued in the same IDLE cycle: display first, CPU op next.
- vdp_read_rq and vdp_write_rq are never both high in one cycle.

Test Plan:
- Address set: control writes 0x34, then 0x52 -> addr=0x1234, no VRAM access, cpu_ack after each write. Then data write 0xAB -> vdp_write_rq with vdp_addr=0x1234 and vdp_wdata=0xAB; addr becomes 0x1235.
- Register write: control writes 0xE0, then 0x81 -> vdp_regs[15:8]=0xE0, no VRAM request.
- Read-ahead: set addr via 0x00, 0x01 (read mode) -> one vdp_read_rq at 0x0100; model returns 0x5A. Then a data read returns 0x5A, and the next read-ahead is issued at 0x0101.
- Wrap: set address 0x3FFF for write, write two bytes -> vdp_addr sequence 0x3FFF, 0x0000.
- Arbitration: disp_rd_rq at 0x0800 in the same cycle as a CPU data write -> display read issued first, then the write; disp_ack and cpu_ack each pulse exactly once.
- Reset mid-write: reset asserted while CPU_WR awaits ack, then ack arrives -> no cpu_ack; state IDLE; flag=0, addr=0.

Source files
------------

// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port -- CPU-facing front end of the VDP (TMS9918A-style programming
// interface). It decodes CPU data/control port accesses, keeps the
// auto-incrementing VRAM address and the read-ahead buffer, and arbitrates CPU
// VRAM traffic against display fetch reads. It is the only master of the
// memory controller's VDP request port.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   cpu_*                 CPU strobe/direction/port select/data, ack + read data
//   status_in/status_rd   status byte in, one-cycle pulse when it is read
//   vdp_regs              write-only register file, reg0 in [7:0]
//   disp_*                display fetch read request/address, data + ack
//   vdp_*                 memory controller request/ack port
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no VRAM transaction in flight; picks display, then CPU op
// DISP_RD | display fetch read issued, waiting for vdp_read_ack
// CPU_RD  | CPU read-ahead issued, waiting for vdp_read_ack
// CPU_WR  | CPU data write issued, waiting for vdp_write_ack

module vdp_cpu_port #(
    parameter int ADDR_W = 14,
    parameter int NREGS  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cpu_rq,
    input  logic                 cpu_we,
    input  logic                 cpu_mode,
    input  logic [7:0]           cpu_wdata,
    output logic [7:0]           cpu_rdata,
    output logic                 cpu_ack,
    input  logic [7:0]           status_in,
    output logic                 status_rd,
    output logic [8*NREGS-1:0]   vdp_regs,
    input  logic                 disp_rd_rq,
    input  logic [ADDR_W-1:0]    disp_addr,
    output logic [7:0]           disp_data,
    output logic                 disp_ack,
    output logic [ADDR_W-1:0]    vdp_addr,
    output logic [7:0]           vdp_wdata,
    input  logic [7:0]           vdp_rdata,
    output logic                 vdp_read_rq,
    input  logic                 vdp_read_ack,
    output logic                 vdp_write_rq,
    input  logic                 vdp_write_ack,
    output logic                 vdp_pipeline_reads
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISP_RD = 2'd1,
        CPU_RD  = 2'd2,
        CPU_WR  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          readbuf_q, readbuf_d;
    logic                flag_q, flag_d;
    logic [7:0]          latch_q, latch_d;
    logic [8*NREGS-1:0]  regs_q, regs_d;
    logic                disp_pend_q, disp_pend_d;
    logic                cpu_pend_q, cpu_pend_d;
    logic                pend_wr_q, pend_wr_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic                cpu_busy_q, cpu_busy_d;
    logic [7:0]          cpu_rdata_q, cpu_rdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                status_rd_q, status_rd_d;
    logic [7:0]          disp_data_q, disp_data_d;
    logic                disp_ack_q, disp_ack_d;
    logic [ADDR_W-1:0]   vdp_addr_q, vdp_addr_d;
    logic [7:0]          vdp_wdata_q, vdp_wdata_d;
    logic                vdp_read_rq_q, vdp_read_rq_d;
    logic                vdp_write_rq_q, vdp_write_rq_d;

    logic [ADDR_W-1:0]   set_addr;

    assign set_addr = ADDR_W'({cpu_wdata[5:0], latch_q});

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        readbuf_d      = readbuf_q;
        flag_d         = flag_q;
        latch_d        = latch_q;
        regs_d         = regs_q;
        disp_pend_d    = disp_pend_q;
        cpu_pend_d     = cpu_pend_q;
        pend_wr_d      = pend_wr_q;
        pend_addr_d    = pend_addr_q;
        cpu_busy_d     = cpu_busy_q;
        cpu_rdata_d    = cpu_rdata_q;
        cpu_ack_d      = 1'b0;
        status_rd_d    = 1'b0;
        disp_data_d    = disp_data_q;
        disp_ack_d     = 1'b0;
        vdp_addr_d     = vdp_addr_q;
        vdp_wdata_d    = vdp_wdata_q;
        vdp_read_rq_d  = 1'b0;
        vdp_write_rq_d = 1'b0;

        if (disp_rd_rq) begin
            disp_pend_d = 1'b1;
        end

        // CPU port decode; VRAM ops are only queued here, the FSM issues them.
        if (cpu_rq && !cpu_busy_q) begin
            if (cpu_mode && cpu_we) begin
                if (!flag_q) begin
                    latch_d   = cpu_wdata;
                    flag_d    = 1'b1;
                    cpu_ack_d = 1'b1;
                end else begin
                    flag_d = 1'b0;
                    if (cpu_wdata[7]) begin
                        if (int'(cpu_wdata[2:0]) < NREGS) begin
                            regs_d[int'(cpu_wdata[2:0])*8 +: 8] = latch_q;
                        end
                        cpu_ack_d = 1'b1;
                    end else if (cpu_wdata[6]) begin
                        addr_d    = set_addr;
                        cpu_ack_d = 1'b1;
                    end else begin
                        // Address set for reading: ack waits for the read-ahead.
                        addr_d      = set_addr + ADDR_W'(1);
                        cpu_pend_d  = 1'b1;
                        pend_wr_d   = 1'b0;
                        pend_addr_d = set_addr;
                        cpu_busy_d  = 1'b1;
                    end
                end
            end else if (cpu_mode) begin
                cpu_rdata_d = status_in;
                status_rd_d = 1'b1;
                flag_d      = 1'b0;
                cpu_ack_d   = 1'b1;
            end else begin
                flag_d      = 1'b0;
                addr_d      = addr_q + ADDR_W'(1);
                cpu_pend_d  = 1'b1;
                pend_wr_d   = cpu_we;
                pend_addr_d = addr_q;
                cpu_busy_d  = 1'b1;
                if (cpu_we) begin
                    // readbuf doubles as the write data holding register.
                    readbuf_d = cpu_wdata;
                end else begin
                    cpu_rdata_d = readbuf_q;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (disp_rd_rq || disp_pend_q) begin
                    state_d       = DISP_RD;
                    disp_pend_d   = 1'b0;
                    vdp_addr_d    = disp_addr;
                    vdp_read_rq_d = 1'b1;
                end else if (cpu_pend_q) begin
                    cpu_pend_d = 1'b0;
                    vdp_addr_d = pend_addr_q;
                    if (pend_wr_q) begin
                        state_d        = CPU_WR;
                        vdp_wdata_d    = readbuf_q;
                        vdp_write_rq_d = 1'b1;
                    end else begin
                        state_d       = CPU_RD;
                        vdp_read_rq_d = 1'b1;
                    end
                end
            end
            DISP_RD: begin
                if (vdp_read_ack) begin
                    disp_data_d = vdp_rdata;
                    disp_ack_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            CPU_RD: begin
                if (vdp_read_ack) begin
                    readbuf_d  = vdp_rdata;
                    cpu_ack_d  = 1'b1;
                    cpu_busy_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            CPU_WR: begin
                if (vdp_write_ack) begin
                    cpu_ack_d  = 1'b1;
                    cpu_busy_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            readbuf_q      <= '0;
            flag_q         <= 1'b0;
            latch_q        <= '0;
            regs_q         <= '0;
            disp_pend_q    <= 1'b0;
            cpu_pend_q     <= 1'b0;
            pend_wr_q      <= 1'b0;
            pend_addr_q    <= '0;
            cpu_busy_q     <= 1'b0;
            cpu_rdata_q    <= '0;
            cpu_ack_q      <= 1'b0;
            status_rd_q    <= 1'b0;
            disp_data_q    <= '0;
            disp_ack_q     <= 1'b0;
            vdp_addr_q     <= '0;
            vdp_wdata_q    <= '0;
            vdp_read_rq_q  <= 1'b0;
            vdp_write_rq_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            readbuf_q      <= readbuf_d;
            flag_q         <= flag_d;
            latch_q        <= latch_d;
            regs_q         <= regs_d;
            disp_pend_q    <= disp_pend_d;
            cpu_pend_q     <= cpu_pend_d;
            pend_wr_q      <= pend_wr_d;
            pend_addr_q    <= pend_addr_d;
            cpu_busy_q     <= cpu_busy_d;
            cpu_rdata_q    <= cpu_rdata_d;
            cpu_ack_q      <= cpu_ack_d;
            status_rd_q    <= status_rd_d;
            disp_data_q    <= disp_data_d;
            disp_ack_q     <= disp_ack_d;
            vdp_addr_q     <= vdp_addr_d;
            vdp_wdata_q    <= vdp_wdata_d;
            vdp_read_rq_q  <= vdp_read_rq_d;
            vdp_write_rq_q <= vdp_write_rq_d;
        end
    end

    assign cpu_rdata          = cpu_rdata_q;
    assign cpu_ack            = cpu_ack_q;
    assign status_rd          = status_rd_q;
    assign vdp_regs           = regs_q;
    assign disp_data          = disp_data_q;
    assign disp_ack           = disp_ack_q;
    assign vdp_addr           = vdp_addr_q;
    assign vdp_wdata          = vdp_wdata_q;
    assign vdp_read_rq        = vdp_read_rq_q;
    assign vdp_write_rq       = vdp_write_rq_q;
    assign vdp_pipeline_reads = 1'b0;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port with a small VRAM model on the memory port.
module tb_vdp_cpu_port;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_rq, cpu_we, cpu_mode;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack;
    logic [7:0]  status_in;
    logic        status_rd;
    logic [63:0] vdp_regs;
    logic        disp_rd_rq;
    logic [13:0] disp_addr;
    logic [7:0]  disp_data;
    logic        disp_ack;
    logic [13:0] vdp_addr;
    logic [7:0]  vdp_wdata, vdp_rdata;
    logic        vdp_read_rq, vdp_read_ack;
    logic        vdp_write_rq, vdp_write_ack;
    logic        vdp_pipeline_reads;

    vdp_cpu_port #(.ADDR_W(14), .NREGS(8)) dut (
        .clock(clock), .reset(reset),
        .cpu_rq(cpu_rq), .cpu_we(cpu_we), .cpu_mode(cpu_mode),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .status_in(status_in), .status_rd(status_rd), .vdp_regs(vdp_regs),
        .disp_rd_rq(disp_rd_rq), .disp_addr(disp_addr),
        .disp_data(disp_data), .disp_ack(disp_ack),
        .vdp_addr(vdp_addr), .vdp_wdata(vdp_wdata), .vdp_rdata(vdp_rdata),
        .vdp_read_rq(vdp_read_rq), .vdp_read_ack(vdp_read_ack),
        .vdp_write_rq(vdp_write_rq), .vdp_write_ack(vdp_write_ack),
        .vdp_pipeline_reads(vdp_pipeline_reads)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // VRAM model state and observation counters, all handled on the negedge.
    logic [7:0]  mem [0:16383];
    logic        hold = 1'b0;
    logic        force_wr_ack = 1'b0;
    int          rd_cnt = 0, wr_cnt = 0;
    logic [13:0] rd_addr = '0;
    int          cpu_ack_cnt = 0, disp_ack_cnt = 0, status_rd_cnt = 0;
    int          rd_rq_cnt = 0, wr_rq_cnt = 0, both_hi = 0;
    logic [7:0]  last_wr_data = '0;
    logic [7:0]  last_disp_data = '0;
    logic [14:0] ev_q[$];

    always @(negedge clock) begin
        vdp_read_ack  = 1'b0;
        vdp_write_ack = force_wr_ack;
        if (rd_cnt > 0) begin
            rd_cnt = rd_cnt - 1;
            if (rd_cnt == 0) begin
                vdp_read_ack = 1'b1;
                vdp_rdata    = mem[rd_addr];
            end
        end
        if (wr_cnt > 0) begin
            wr_cnt = wr_cnt - 1;
            if (wr_cnt == 0) vdp_write_ack = 1'b1;
        end
        if (vdp_read_rq && vdp_write_rq) both_hi = both_hi + 1;
        if (vdp_read_rq) begin
            rd_rq_cnt = rd_rq_cnt + 1;
            ev_q.push_back({1'b0, vdp_addr});
            if (!hold) begin
                rd_cnt  = 2;
                rd_addr = vdp_addr;
            end
        end
        if (vdp_write_rq) begin
            wr_rq_cnt    = wr_rq_cnt + 1;
            last_wr_data = vdp_wdata;
            ev_q.push_back({1'b1, vdp_addr});
            if (!hold) begin
                wr_cnt        = 2;
                mem[vdp_addr] = vdp_wdata;
            end
        end
        if (cpu_ack) cpu_ack_cnt = cpu_ack_cnt + 1;
        if (status_rd) status_rd_cnt = status_rd_cnt + 1;
        if (disp_ack) begin
            disp_ack_cnt   = disp_ack_cnt + 1;
            last_disp_data = disp_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1 with the strobe dropped.
    task automatic cpu_issue(input logic mode, input logic we, input logic [7:0] d);
        cpu_mode  = mode;
        cpu_we    = we;
        cpu_wdata = d;
        cpu_rq    = 1'b1;
        @(posedge clock);
        #1;
        cpu_rq = 1'b0;
    endtask

    task automatic cpu_op(input string tag, input logic mode, input logic we,
                          input logic [7:0] d, output logic [7:0] rd);
        logic ok;
        ok = 1'b0;
        rd = '0;
        cpu_issue(mode, we, d);
        for (int i = 0; i < 40; i++) begin
            if (cpu_ack) begin
                ok = 1'b1;
                rd = cpu_rdata;
                break;
            end
            @(posedge clock);
            #1;
        end
        chk(tag, ok, 1'b1);
        @(posedge clock);
        #1;
    endtask

    logic [7:0] rd;
    int         base_cpu, base_disp, base_wr;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h0100] = 8'h5A;
        mem[14'h0101] = 8'h77;
        mem[14'h0800] = 8'h3C;
        reset = 1'b1; cpu_rq = 1'b0; cpu_we = 1'b0; cpu_mode = 1'b0;
        cpu_wdata = '0; status_in = '0; disp_rd_rq = 1'b0; disp_addr = '0;
        vdp_rdata = '0; vdp_read_ack = 1'b0; vdp_write_ack = 1'b0;
        cycles(3);
        reset = 1'b0;
        cycles(1);

        chk("reset_outputs", {cpu_ack, status_rd, disp_ack, vdp_read_rq, vdp_write_rq,
                              vdp_pipeline_reads}, 6'b0);
        chk("reset_regs", vdp_regs, 64'h0);
        chk("reset_buses", {cpu_rdata, disp_data, vdp_addr, vdp_wdata}, 38'h0);

        // Address set 0x1234 for writing, then a data write.
        ev_q.delete();
        cpu_issue(1'b1, 1'b1, 8'h34);
        chk("first_ctl_ack_next_cycle", cpu_ack, 1'b1);
        cycles(1);
        cpu_op("addr_set_ack", 1'b1, 1'b1, 8'h52, rd);
        chk("addr_set_no_vram", ev_q.size(), 0);
        cpu_op("wr_ack", 1'b0, 1'b1, 8'hAB, rd);
        chk("wr_event", ev_q[0], {1'b1, 14'h1234});
        chk("wr_data", last_wr_data, 8'hAB);
        cpu_op("wr2_ack", 1'b0, 1'b1, 8'hCD, rd);
        chk("wr2_addr_incr", ev_q[1], {1'b1, 14'h1235});

        // Register write reg1 = 0xE0.
        ev_q.delete();
        cpu_op("reg_b0", 1'b1, 1'b1, 8'hE0, rd);
        cpu_op("reg_b1", 1'b1, 1'b1, 8'h81, rd);
        chk("reg1", vdp_regs, 64'h0000_0000_0000_E000);
        chk("reg_no_vram", ev_q.size(), 0);

        // Read-ahead from address set, then data reads.
        cpu_op("ra_b0", 1'b1, 1'b1, 8'h00, rd);
        cpu_op("ra_b1", 1'b1, 1'b1, 8'h01, rd);
        chk("ra_one_read", ev_q.size(), 1);
        chk("ra_addr", ev_q[0], {1'b0, 14'h0100});
        cpu_op("rd1_ack", 1'b0, 1'b0, 8'h00, rd);
        chk("rd1_data", rd, 8'h5A);
        chk("rd1_next_ra", ev_q[1], {1'b0, 14'h0101});
        cpu_op("rd2_ack", 1'b0, 1'b0, 8'h00, rd);
        chk("rd2_data", rd, 8'h77);

        // Status read clears the flag.
        status_in = 8'hA5;
        cpu_op("ctl_b0_half", 1'b1, 1'b1, 8'h10, rd);
        cpu_op("status_ack", 1'b1, 1'b0, 8'h00, rd);
        chk("status_data", rd, 8'hA5);
        chk("status_rd_pulse", status_rd_cnt, 1);
        ev_q.delete();
        cpu_op("fl_b0", 1'b1, 1'b1, 8'h22, rd);
        cpu_op("fl_b1", 1'b1, 1'b1, 8'h40, rd);
        cpu_op("fl_wr", 1'b0, 1'b1, 8'h01, rd);
        chk("flag_cleared_addr", ev_q[0], {1'b1, 14'h0022});

        // Wrap 3FFF -> 0000.
        ev_q.delete();
        cpu_op("wrap_b0", 1'b1, 1'b1, 8'hFF, rd);
        cpu_op("wrap_b1", 1'b1, 1'b1, 8'h7F, rd);
        cpu_op("wrap_w0", 1'b0, 1'b1, 8'h11, rd);
        cpu_op("wrap_w1", 1'b0, 1'b1, 8'h12, rd);
        chk("wrap_a0", ev_q[0], {1'b1, 14'h3FFF});
        chk("wrap_a1", ev_q[1], {1'b1, 14'h0000});

        // Display read and CPU write arriving together.
        cpu_op("arb_b0", 1'b1, 1'b1, 8'h00, rd);
        cpu_op("arb_b1", 1'b1, 1'b1, 8'h42, rd);
        ev_q.delete();
        base_cpu  = cpu_ack_cnt;
        base_disp = disp_ack_cnt;
        disp_addr  = 14'h0800;
        disp_rd_rq = 1'b1;
        cpu_mode = 1'b0; cpu_we = 1'b1; cpu_wdata = 8'h99; cpu_rq = 1'b1;
        @(posedge clock);
        #1;
        disp_rd_rq = 1'b0;
        cpu_rq     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cpu_ack_cnt > base_cpu && disp_ack_cnt > base_disp) break;
            cycles(1);
        end
        cycles(5);
        chk("arb_first_disp", ev_q[0], {1'b0, 14'h0800});
        chk("arb_then_wr", ev_q[1], {1'b1, 14'h0200});
        chk("arb_disp_acks", disp_ack_cnt - base_disp, 1);
        chk("arb_cpu_acks", cpu_ack_cnt - base_cpu, 1);
        chk("arb_disp_data", last_disp_data, 8'h3C);

        // Reset while a write awaits its ack.
        cpu_op("rst_b0", 1'b1, 1'b1, 8'h10, rd);
        cpu_op("rst_b1", 1'b1, 1'b1, 8'h45, rd);
        hold    = 1'b1;
        base_wr = wr_rq_cnt;
        cpu_issue(1'b0, 1'b1, 8'h55);
        for (int i = 0; i < 20; i++) begin
            if (wr_rq_cnt > base_wr) break;
            cycles(1);
        end
        chk("rst_wr_issued", wr_rq_cnt - base_wr, 1);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(1);
        chk("rst_regs_cleared", vdp_regs, 64'h0);
        chk("rst_outputs", {cpu_ack, vdp_read_rq, vdp_write_rq, vdp_addr}, 17'h0);
        base_cpu = cpu_ack_cnt;
        force_wr_ack = 1'b1;
        cycles(1);
        force_wr_ack = 1'b0;
        cycles(5);
        hold = 1'b0;
        chk("rst_late_ack_ignored", cpu_ack_cnt - base_cpu, 0);
        ev_q.delete();
        cpu_op("rst_wr_after", 1'b0, 1'b1, 8'h66, rd);
        chk("rst_addr_zero", ev_q[0], {1'b1, 14'h0000});
        cpu_op("rst_fl_b0", 1'b1, 1'b1, 8'h05, rd);
        cpu_op("rst_fl_b1", 1'b1, 1'b1, 8'h40, rd);
        cpu_op("rst_fl_wr", 1'b0, 1'b1, 8'h67, rd);
        chk("rst_flag_zero", ev_q[1], {1'b1, 14'h0005});

        chk("never_dual_rq", both_hi, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
